// File: rtl/uart_tx.sv
// UART transmitter: one byte per request, framed as start, LSB-first data, stop bit(s).
// The line goes low the cycle after acceptance. Requests made while busy are dropped.
module uart_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cycle_cnt_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    txd_q;
  logic                    busy_q;

  logic bit_end;
  assign bit_end = (cycle_cnt_q == CNT_LAST);

  // bit_cnt_q counts data bits in DATA and elapsed stop bits in STOP, so the
  // cycle counter never has to span more than one bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cycle_cnt_q <= '0;
          bit_cnt_q   <= '0;
          if (uart_tx_en) begin
            shift_q <= uart_tx_data;
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            state_q     <= DATA;
            txd_q       <= shift_q[0];
          end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cycle_cnt_q <= '0;
            shift_q     <= shift_q >> 1;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= STOP;
              txd_q     <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              txd_q     <= shift_q[1];
            end
          end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            cycle_cnt_q <= '0;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at C=10: one instance with one stop bit, one with two.
module tb_uart_tx;

  localparam int C = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       en1, en2;
  logic [7:0] dat1, dat2;
  logic       txd1, busy1, txd2, busy2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .uart_txd(txd1), .uart_tx_busy(busy1),
    .uart_tx_en(en1), .uart_tx_data(dat1)
  );

  uart_tx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .uart_txd(txd2), .uart_tx_busy(busy2),
    .uart_tx_en(en2), .uart_tx_data(dat2)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_txd"}, txd1, 1'b1);
      check({tag, "_busy"}, busy1, 1'b0);
      step();
    end
  endtask

  // Expected line level for frame cycle i (0-based from the first start cycle).
  function automatic logic frame_bit(input logic [7:0] d, input int i, input int nstop);
    int slot = i / C;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return (slot < 9 + nstop) ? 1'b1 : 1'bx;
  endfunction

  // Called on the first cycle after acceptance; leaves time one cycle after busy falls.
  // With inject set, a 0x5C request and data changes arrive mid-DATA.
  task automatic check_frame1(input string tag, input logic [7:0] d, input bit inject);
    for (int i = 0; i < 10 * C; i++) begin
      if (inject && i == 35) begin en1 = 1'b1; dat1 = 8'h5C; end
      if (inject && i == 36) en1 = 1'b0;
      if (inject && i == 47) dat1 = 8'hFF;
      check({tag, "_busy"}, busy1, 1'b1);
      check({tag, "_txd"}, txd1, frame_bit(d, i, 1));
      step();
    end
    check({tag, "_busy_fall"}, busy1, 1'b0);
    check({tag, "_txd_after"}, txd1, 1'b1);
  endtask

  initial begin
    reset = 1'b1; en1 = 1'b0; en2 = 1'b0; dat1 = 8'h00; dat2 = 8'h00;
    #1;
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      check("rst_txd", txd1, 1'b1);
      check("rst_busy", busy1, 1'b0);
      check("rst_txd2", txd2, 1'b1);
      step();
    end
    reset = 1'b0;
    check_idle("idle50", 50);

    // Single frame 0x55.
    en1 = 1'b1; dat1 = 8'h55;
    step();
    en1 = 1'b0; dat1 = 8'h00;
    check_frame1("f55", 8'h55, 1'b0);
    check_idle("post55", 10);

    // Back-to-back 0x00 then 0xFF with the request held.
    en1 = 1'b1; dat1 = 8'h00;
    step();
    dat1 = 8'hFF;
    check_frame1("b2b00", 8'h00, 1'b0);
    step();
    en1 = 1'b0;
    check_frame1("b2bFF", 8'hFF, 1'b0);
    check_idle("postb2b", 20);

    // Request during DATA is dropped and data changes after capture are ignored.
    en1 = 1'b1; dat1 = 8'hA3;
    step();
    en1 = 1'b0;
    check_frame1("fA3", 8'hA3, 1'b1);
    check_idle("noqueue", 30);

    // Reset in the middle of data bit 3 of 0xF0.
    en1 = 1'b1; dat1 = 8'hF0;
    step();
    en1 = 1'b0;
    for (int i = 0; i < 43; i++) begin
      check("fF0_txd", txd1, frame_bit(8'hF0, i, 1));
      step();
    end
    check("fF0_bit3_pre", txd1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_txd", txd1, 1'b1);
    check("midrst_busy", busy1, 1'b0);
    step();
    reset = 1'b0;
    check_idle("postrst", 5);
    en1 = 1'b1; dat1 = 8'h81;
    step();
    en1 = 1'b0;
    check_frame1("f81", 8'h81, 1'b0);

    // Request coinciding with reset sends nothing.
    en1 = 1'b1; dat1 = 8'h3C; reset = 1'b1;
    step();
    en1 = 1'b0; reset = 1'b0;
    check_idle("rst_en", 20);

    // Two stop bits: busy spans 11*C cycles.
    en2 = 1'b1; dat2 = 8'h96;
    step();
    en2 = 1'b0; dat2 = 8'h00;
    for (int i = 0; i < 11 * C; i++) begin
      check("sb2_busy", busy2, 1'b1);
      check("sb2_txd", txd2, frame_bit(8'h96, i, 2));
      step();
    end
    check("sb2_busy_fall", busy2, 1'b0);
    check("sb2_txd_after", txd2, 1'b1);
    check("sb2_dut1_quiet", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
